// File: rtl/control_sequencer.sv
// Microstep sequencer for the 8-bit bus CPU: walks T0..T4 per instruction and
// decodes opcode, step and flags into the 15-bit control word.
module control_sequencer #(
  parameter bit EARLY_END = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic [7:0]  instr,
  input  logic        flag_c,
  input  logic        flag_z,
  output logic [14:0] ctrl,
  output logic [2:0]  step,
  output logic        halted
);

  typedef enum logic [2:0] {
    T0 = 3'd0,
    T1 = 3'd1,
    T2 = 3'd2,
    T3 = 3'd3,
    T4 = 3'd4
  } step_t;

  localparam logic [14:0] MAR_IN   = 15'h0001;
  localparam logic [14:0] RAM_IN   = 15'h0002;
  localparam logic [14:0] RAM_OUT  = 15'h0004;
  localparam logic [14:0] IR_IN    = 15'h0008;
  localparam logic [14:0] IR_OUT   = 15'h0010;
  localparam logic [14:0] A_IN     = 15'h0020;
  localparam logic [14:0] A_OUT    = 15'h0040;
  localparam logic [14:0] ALU_OUT  = 15'h0080;
  localparam logic [14:0] ALU_SUB  = 15'h0100;
  localparam logic [14:0] B_IN     = 15'h0200;
  localparam logic [14:0] OUT_IN   = 15'h0400;
  localparam logic [14:0] PC_INC   = 15'h0800;
  localparam logic [14:0] PC_OUT   = 15'h1000;
  localparam logic [14:0] JUMP     = 15'h2000;
  localparam logic [14:0] FLAGS_IN = 15'h4000;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  step_t       state;
  step_t       last_step;
  step_t       end_step;
  logic [3:0]  opcode;
  logic [14:0] word;
  logic        unused_operand;

  assign opcode = instr[7:4];
  // The operand nibble reaches the bus through the IR itself, never through here.
  assign unused_operand = ^instr[3:0];

  always_comb begin
    last_step = T1;
    case (opcode)
      OP_LDA, OP_STA: last_step = T3;
      OP_ADD, OP_SUB: last_step = T4;
      OP_LDI, OP_JMP, OP_JC, OP_JZ, OP_OUT, OP_HLT: last_step = T2;
      default: last_step = T1;
    endcase
  end

  assign end_step = EARLY_END ? last_step : T4;

  // Each step enables at most one bus driver: ram_out, ir_out, a_out, alu_out, pc_out.
  always_comb begin
    word = '0;
    case (state)
      T0: word = PC_OUT | MAR_IN;
      T1: word = RAM_OUT | IR_IN | PC_INC;
      default: begin
        case (opcode)
          OP_LDA: begin
            if (state == T2) word = IR_OUT | MAR_IN;
            else if (state == T3) word = RAM_OUT | A_IN;
          end
          OP_ADD, OP_SUB: begin
            if (state == T2) word = IR_OUT | MAR_IN;
            else if (state == T3) word = RAM_OUT | B_IN;
            else if (state == T4)
              word = ALU_OUT | A_IN | FLAGS_IN | ((opcode == OP_SUB) ? ALU_SUB : 15'h0000);
          end
          OP_STA: begin
            if (state == T2) word = IR_OUT | MAR_IN;
            else if (state == T3) word = A_OUT | RAM_IN;
          end
          OP_LDI: if (state == T2) word = IR_OUT | A_IN;
          OP_JMP: if (state == T2) word = IR_OUT | JUMP;
          OP_JC:  if (state == T2 && flag_c) word = IR_OUT | JUMP;
          OP_JZ:  if (state == T2 && flag_z) word = IR_OUT | JUMP;
          OP_OUT: if (state == T2) word = A_OUT | OUT_IN;
          default: word = '0;
        endcase
      end
    endcase
  end

  // Reset gates the word asynchronously so nothing fires while rst is high.
  assign ctrl = (rst || halted || !run) ? '0 : word;
  assign step = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= T0;
      halted <= 1'b0;
    end else if (run && !halted) begin
      if (state == T2 && opcode == OP_HLT) begin
        halted <= 1'b1;
        state  <= T0;
      end else if (state == end_step) begin
        state <= T0;
      end else begin
        state <= step_t'(state + 3'd1);
      end
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: directed scenarios plus a randomized run
// against a table-driven model, on both EARLY_END settings.
module tb_control_sequencer;

  localparam logic [14:0] MAR_IN   = 15'h0001;
  localparam logic [14:0] RAM_IN   = 15'h0002;
  localparam logic [14:0] RAM_OUT  = 15'h0004;
  localparam logic [14:0] IR_IN    = 15'h0008;
  localparam logic [14:0] IR_OUT   = 15'h0010;
  localparam logic [14:0] A_IN     = 15'h0020;
  localparam logic [14:0] A_OUT    = 15'h0040;
  localparam logic [14:0] ALU_OUT  = 15'h0080;
  localparam logic [14:0] ALU_SUB  = 15'h0100;
  localparam logic [14:0] B_IN     = 15'h0200;
  localparam logic [14:0] OUT_IN   = 15'h0400;
  localparam logic [14:0] PC_INC   = 15'h0800;
  localparam logic [14:0] PC_OUT   = 15'h1000;
  localparam logic [14:0] JUMP     = 15'h2000;
  localparam logic [14:0] FLAGS_IN = 15'h4000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic [7:0]  instr = 8'h00;
  logic        flag_c = 1'b0;
  logic        flag_z = 1'b0;
  logic [14:0] ctrl, ctrl0;
  logic [2:0]  step, step0;
  logic        halted, halted0;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  control_sequencer #(.EARLY_END(1'b1)) dut (
    .clk(clk), .rst(rst), .run(run), .instr(instr), .flag_c(flag_c), .flag_z(flag_z),
    .ctrl(ctrl), .step(step), .halted(halted)
  );

  control_sequencer #(.EARLY_END(1'b0)) dut0 (
    .clk(clk), .rst(rst), .run(run), .instr(instr), .flag_c(flag_c), .flag_z(flag_z),
    .ctrl(ctrl0), .step(step0), .halted(halted0)
  );

  // Instruction length in steps, fetch included.
  function automatic int instr_len(input logic [3:0] op);
    case (op)
      4'h1, 4'h4: return 4;
      4'h2, 4'h3: return 5;
      4'h5, 4'h6, 4'h7, 4'h8, 4'hE, 4'hF: return 3;
      default: return 2;
    endcase
  endfunction

  // Microprogram table: control word for opcode op at step t.
  function automatic logic [14:0] micro(input logic [3:0] op, input int t, input logic c, input logic z);
    logic [14:0] w;
    w = '0;
    if (t == 0) w = PC_OUT | MAR_IN;
    else if (t == 1) w = RAM_OUT | IR_IN | PC_INC;
    else begin
      case (op)
        4'h1: w = (t == 2) ? (IR_OUT | MAR_IN) : (t == 3) ? (RAM_OUT | A_IN) : 15'h0;
        4'h2: w = (t == 2) ? (IR_OUT | MAR_IN) : (t == 3) ? (RAM_OUT | B_IN) :
                  (t == 4) ? (ALU_OUT | A_IN | FLAGS_IN) : 15'h0;
        4'h3: w = (t == 2) ? (IR_OUT | MAR_IN) : (t == 3) ? (RAM_OUT | B_IN) :
                  (t == 4) ? (ALU_OUT | A_IN | FLAGS_IN | ALU_SUB) : 15'h0;
        4'h4: w = (t == 2) ? (IR_OUT | MAR_IN) : (t == 3) ? (A_OUT | RAM_IN) : 15'h0;
        4'h5: w = (t == 2) ? (IR_OUT | A_IN) : 15'h0;
        4'h6: w = (t == 2) ? (IR_OUT | JUMP) : 15'h0;
        4'h7: w = (t == 2 && c) ? (IR_OUT | JUMP) : 15'h0;
        4'h8: w = (t == 2 && z) ? (IR_OUT | JUMP) : 15'h0;
        4'hE: w = (t == 2) ? (A_OUT | OUT_IN) : 15'h0;
        default: w = '0;
      endcase
    end
    return w;
  endfunction

  // Bus-driver invariant on both instances, every cycle.
  always @(negedge clk) begin
    vectors++;
    if ($countones({ctrl[2], ctrl[4], ctrl[6], ctrl[7], ctrl[12]}) > 1 ||
        $countones({ctrl0[2], ctrl0[4], ctrl0[6], ctrl0[7], ctrl0[12]}) > 1) begin
      miscompares++;
      $display("FAIL bus_onehot ctrl=%h ctrl0=%h required at most one driver", ctrl, ctrl0);
    end
  end

  task automatic apply_reset();
    rst = 1'b1;
    run = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    run = 1'b1;
    instr = 8'h5A;
    #1;
    vectors++;
    if (ctrl !== 15'h0 || step !== 3'd0 || halted !== 1'b0 ||
        ctrl0 !== 15'h0 || step0 !== 3'd0 || halted0 !== 1'b0) begin
      miscompares++;
      $display("FAIL reset ctrl=%h step=%0d halted=%b ctrl0=%h step0=%0d halted0=%b required all 0",
               ctrl, step, halted, ctrl0, step0, halted0);
    end
    apply_reset();
  endtask

  task automatic test_fetch_ldi();
    logic [14:0] ec [4];
    logic [2:0]  es [4];
    ec = '{15'h1001, 15'h080C, 15'h0030, 15'h1001};
    es = '{3'd0, 3'd1, 3'd2, 3'd0};
    apply_reset();
    instr = 8'h5A;
    run = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      vectors++;
      if (ctrl !== ec[i] || step !== es[i]) begin
        miscompares++;
        $display("FAIL fetch_ldi[%0d] ctrl=%h step=%0d required ctrl=%h step=%0d", i, ctrl, step, ec[i], es[i]);
      end
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic test_add_sub();
    logic [7:0] ops [2];
    logic [14:0] t4 [2];
    ops = '{8'h2F, 8'h3F};
    t4 = '{15'h40A0, 15'h41A0};
    for (int k = 0; k < 2; k++) begin
      apply_reset();
      instr = ops[k];
      run = 1'b1;
      for (int i = 0; i < 6; i++) begin
        #1;
        vectors++;
        if (step !== 3'(i % 5)) begin
          miscompares++;
          $display("FAIL add_sub_step op=%h[%0d] step=%0d required %0d", ops[k], i, step, i % 5);
        end
        if (i == 4) begin
          vectors++;
          if (ctrl !== t4[k]) begin
            miscompares++;
            $display("FAIL add_sub_t4 op=%h ctrl=%h required %h", ops[k], ctrl, t4[k]);
          end
        end
        @(posedge clk);
        @(negedge clk);
      end
    end
  endtask

  task automatic test_jc();
    logic [14:0] t2 [2];
    t2 = '{15'h0000, 15'h2010};
    for (int c = 0; c < 2; c++) begin
      apply_reset();
      instr = 8'h73;
      flag_c = c[0];
      run = 1'b1;
      for (int i = 0; i < 4; i++) begin
        #1;
        vectors++;
        if (step !== 3'(i % 3)) begin
          miscompares++;
          $display("FAIL jc_step c=%0d[%0d] step=%0d required %0d", c, i, step, i % 3);
        end
        if (i == 2) begin
          vectors++;
          if (ctrl !== t2[c]) begin
            miscompares++;
            $display("FAIL jc_t2 c=%0d ctrl=%h required %h", c, ctrl, t2[c]);
          end
        end
        @(posedge clk);
        @(negedge clk);
      end
    end
    flag_c = 1'b0;
  endtask

  task automatic test_hlt();
    apply_reset();
    instr = 8'hF0;
    run = 1'b1;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
    end
    vectors++;
    if (halted !== 1'b0 || step !== 3'd2 || ctrl !== 15'h0) begin
      miscompares++;
      $display("FAIL hlt_t2 halted=%b step=%0d ctrl=%h required 0/2/0000", halted, step, ctrl);
    end
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      vectors++;
      if (halted !== 1'b1 || step !== 3'd0 || ctrl !== 15'h0) begin
        miscompares++;
        $display("FAIL hlt_hold[%0d] halted=%b step=%0d ctrl=%h required 1/0/0000", i, halted, step, ctrl);
      end
      @(posedge clk);
      @(negedge clk);
    end
    rst = 1'b1;
    #1;
    vectors++;
    if (halted !== 1'b0) begin
      miscompares++;
      $display("FAIL hlt_clear halted=%b required 0", halted);
    end
    apply_reset();
  endtask

  task automatic test_pause_reset();
    apply_reset();
    instr = 8'h1F;
    run = 1'b1;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
    end
    run = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      vectors++;
      if (step !== 3'd3 || ctrl !== 15'h0) begin
        miscompares++;
        $display("FAIL pause[%0d] step=%0d ctrl=%h required 3/0000", i, step, ctrl);
      end
      @(posedge clk);
      @(negedge clk);
    end
    run = 1'b1;
    #1;
    vectors++;
    if (step !== 3'd3 || ctrl !== 15'h0024) begin
      miscompares++;
      $display("FAIL resume step=%0d ctrl=%h required 3/0024", step, ctrl);
    end
    rst = 1'b1;
    #1;
    vectors++;
    if (step !== 3'd0 || ctrl !== 15'h0) begin
      miscompares++;
      $display("FAIL midreset step=%0d ctrl=%h required 0/0000", step, ctrl);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    vectors++;
    if (step !== 3'd0 || ctrl !== 15'h1001) begin
      miscompares++;
      $display("FAIL refetch step=%0d ctrl=%h required 0/1001", step, ctrl);
    end
  endtask

  task automatic test_early_end();
    logic [2:0]  es0 [6];
    logic [14:0] ec0 [6];
    logic [2:0]  es1 [6];
    es0 = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
    ec0 = '{15'h1001, 15'h080C, 15'h0, 15'h0, 15'h0, 15'h1001};
    es1 = '{3'd0, 3'd1, 3'd0, 3'd1, 3'd0, 3'd1};
    apply_reset();
    instr = 8'h00;
    run = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      vectors++;
      if (step0 !== es0[i] || ctrl0 !== ec0[i] || step !== es1[i]) begin
        miscompares++;
        $display("FAIL nop_len[%0d] step0=%0d ctrl0=%h step=%0d required %0d/%h/%0d",
                 i, step0, ctrl0, step, es0[i], ec0[i], es1[i]);
      end
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic test_random();
    int ms [2];
    logic [3:0]  op;
    logic [14:0] ectl;
    logic [14:0] got_c;
    logic [2:0]  got_s;
    apply_reset();
    ms = '{0, 0};
    for (int n = 0; n < 400; n++) begin
      if (ms[0] == 0 && $urandom_range(0, 1) == 1) begin
        op = 4'($urandom_range(0, 14));
        instr = {op, 4'($urandom_range(0, 15))};
      end
      run = ($urandom_range(0, 9) < 8);
      flag_c = 1'($urandom_range(0, 1));
      flag_z = 1'($urandom_range(0, 1));
      #1;
      for (int k = 0; k < 2; k++) begin
        ectl = run ? micro(instr[7:4], ms[k], flag_c, flag_z) : 15'h0;
        got_c = (k == 0) ? ctrl : ctrl0;
        got_s = (k == 0) ? step : step0;
        vectors++;
        if (got_c !== ectl || got_s !== 3'(ms[k]) || halted !== 1'b0 || halted0 !== 1'b0) begin
          miscompares++;
          $display("FAIL random[%0d] ee=%0d instr=%h run=%b ctrl=%h step=%0d required ctrl=%h step=%0d",
                   n, 1 - k, instr, run, got_c, got_s, ectl, ms[k]);
        end
      end
      @(posedge clk);
      if (run) begin
        ms[0] = (ms[0] >= instr_len(instr[7:4]) - 1) ? 0 : ms[0] + 1;
        ms[1] = (ms[1] == 4) ? 0 : ms[1] + 1;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_fetch_ldi();
    test_add_sub();
    test_jc();
    test_hlt();
    test_pause_reset();
    test_early_end();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
